pipe_link_channel: RTL
======================

// Module: pipe_link_channel
// PURPOSE
//  PIPE-side link model that sits directly downstream of two PCIe top-level instances:
//  side A (e.g. RC) and side B (e.g. EP). It carries each side's pipe_txdata/txvalid to
//  the other side's pipe_rxdata/rxvalid.
//  Adds fixed latency, a link-training/flush FSM, and one-shot error injection for
//  DLL replay/NAK testing.
//  Also provides beat/drop statistics.
// PARAMETERS
//  PIPE_DATA_WIDTH  256    width of each PIPE data bus
//  LATENCY          4      channel delay in cycles, input beat to rx output (must be >=1)
//  LINKUP_CYCLES    16     cycles spent in TRAINING before LINK_UP (must be >=1)
// PORTS
//  clk            in   1      single clock
//  rst_n          in   1      synchronous reset, active-low
//  a_txdata_i     in   W      side A transmit data (W = PIPE_DATA_WIDTH)
//  a_txvalid_i    in   1      side A transmit valid
//  a_rxdata_o     out  W      data delivered to side A (from B)
//  a_rxvalid_o    out  1      valid delivered to side A
//  b_txdata_i     in   W      side B transmit data
//  b_txvalid_i    in   1      side B transmit valid
//  b_rxdata_o     out  W      data delivered to side B (from A)
//  b_rxvalid_o    out  1      valid delivered to side B
//  link_down_i    in   1      request link down + retrain (level)
//  link_up_o      out  1      1 while FSM is in LINK_UP
//  inj_en_i       in   1      arm injection on 0->1 edge
//  inj_dir_i      in   1      0: A->B, 1: B->A
//  inj_mode_i     in   2      0 none, 1 flip bit, 2 drop beat, 3 reserved (= none)
//  inj_beat_i     in   16     index of valid beat to corrupt, counted from 0 after arming
//  inj_bit_i      in   $clog2(W)  bit to flip in mode 1
//  inj_done_o     out  1      1-cycle pulse when injection is applied
//  beats_ab_o     out  32     valid beats delivered to B (wraps at 2^32)
//  beats_ba_o     out  32     valid beats delivered to A (wraps at 2^32)
//  drops_o        out  16     beats dropped by injection (saturates at 0xFFFF)
// BEHAVIOUR
//  Reset:
//   - All outputs are 0; FSM enters RESET_WAIT.
//   - Delay-line valids and data are cleared; injection is disarmed.
//  FSM states and transitions:
//   - RESET_WAIT -> TRAINING after 1 cycle.
//   - TRAINING: counts LINKUP_CYCLES cycles -> LINK_UP.
//   - LINK_UP: link_up_o=1. link_down_i=1 in TRAINING or LINK_UP -> FLUSH.
//   - FLUSH: every delay-line stage valid is cleared and injection is disarmed.
//     Stays in FLUSH while link_down_i=1, then -> TRAINING with the counter reloaded.
//  Datapath:
//   - Only in LINK_UP are tx beats accepted into the delay lines; otherwise inputs are
//     discarded.
//   - A beat accepted in cycle t appears on rx at cycle t+LATENCY, data unmodified unless
//     injected.
//   - rxdata_o = 0 whenever rxvalid_o = 0.
//   - Beats already in flight when the FSM leaves LINK_UP are flushed and never delivered.
//   - A beat arriving in the same cycle link_down_i rises is discarded.
//  Injection:
//   - Arm on an inj_en_i rising edge while in LINK_UP and not already armed.
//     dir/mode/beat/bit are latched at that edge. An edge while armed is ignored.
//   - Beat counting starts the cycle after arming and counts accepted valid beats in the
//     latched direction.
//   - When count == latched beat, the mode is applied to that beat at delay-line entry:
//     mode 1 XORs the latched bit; mode 2 forces the beat's valid to 0 and drops_o++.
//   - inj_done_o pulses in that same cycle, then injection disarms.
//   - Modes 0 and 3 still pulse inj_done_o at the matching beat; data is untouched.
//  Counters:
//   - beats_* increment on delivered rxvalid.
//   - Counters are cleared only by rst_n, not by link down.
//  Independence: A->B and B->A are fully independent; simultaneous beats in both
//   directions are allowed every cycle.
// STRUCTURE
//  - Package pipe_ch_pkg: typedef enum {RESET_WAIT, TRAINING, LINK_UP, FLUSH}
//    pipe_ch_state_t; typedef enum logic[1:0] {INJ_NONE, INJ_FLIP, INJ_DROP, INJ_RSVD}
//    pipe_inj_mode_t.
//  - Sub-module pipe_delay_line (params WIDTH, DEPTH; ports clk, rst_n, flush_i, valid_i,
//    data_i, valid_o, data_o), instantiated once per direction.
//  - The top holds the FSM, injection logic and counters.
// TESTING
//  1. Reset then idle: after rst_n release, link_up_o rises exactly 1+16 cycles later;
//     all rx outputs stay 0.
//  2. Latency: LINK_UP, A sends 0xDEAD..01 at cycle t -> b_rxvalid_o=1 with the same
//     data at t+4; beats_ab_o=1. Back-to-back 8 beats both directions -> 8 contiguous
//     beats each side, counters 8/8.
//  3. Flip: arm dir=0, mode=1, beat=2, bit=0; send beats 0x10,0x11,0x12 -> B receives
//     0x10,0x11,0x13; inj_done_o pulses on the third entry cycle only.
//  4. Drop: arm dir=1, mode=2, beat=0; B sends 3 beats -> A receives beats 2 and 3 only;
//     drops_o=1; beats_ba_o=2.
//  5. Mid-flight link down: 3 beats in flight, pulse link_down_i 1 cycle -> no beats
//     delivered; link_up_o low; relinks after 1+16 cycles; counters retained.
//  6. Reset during LINK_UP with injection armed -> all outputs 0 the next cycle;
//     injection disarmed; counters 0.

Source files
------------

// File: rtl/pipe_link_channel_pkg.sv
// rtl/pipe_link_channel_pkg.sv - shared types and helpers for the PIPE link channel
package pipe_ch_pkg;

  // Link-training / flush FSM states
  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    TRAINING   = 2'd1,
    LINK_UP    = 2'd2,
    FLUSH      = 2'd3
  } pipe_ch_state_t;

  // Error injection modes; INJ_RSVD behaves like INJ_NONE
  typedef enum logic [1:0] {
    INJ_NONE = 2'd0,
    INJ_FLIP = 2'd1,
    INJ_DROP = 2'd2,
    INJ_RSVD = 2'd3
  } pipe_inj_mode_t;

  localparam int DROP_CNT_W = 16;
  localparam int BEAT_CNT_W = 32;

  // Saturating increment for the drop counter
  function automatic logic [DROP_CNT_W-1:0] sat_inc16(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_link_channel_delay_line.sv
// rtl/pipe_link_channel_delay_line.sv - fixed-depth valid/data shift register for one direction
module pipe_delay_line #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // Shift beats one stage per cycle; data is stored zeroed when invalid so the
  // output data is 0 whenever the output valid is 0. Flush empties every stage.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= valid_i ? data_i : '0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/pipe_link_channel.sv
// rtl/pipe_link_channel.sv - PIPE link model: latency, training/flush FSM, error injection, stats
module pipe_link_channel
  import pipe_ch_pkg::*;
#(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int LATENCY         = 4,
  parameter int LINKUP_CYCLES   = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [PIPE_DATA_WIDTH-1:0]         a_txdata_i,
  input  logic                               a_txvalid_i,
  output logic [PIPE_DATA_WIDTH-1:0]         a_rxdata_o,
  output logic                               a_rxvalid_o,
  input  logic [PIPE_DATA_WIDTH-1:0]         b_txdata_i,
  input  logic                               b_txvalid_i,
  output logic [PIPE_DATA_WIDTH-1:0]         b_rxdata_o,
  output logic                               b_rxvalid_o,
  input  logic                               link_down_i,
  output logic                               link_up_o,
  input  logic                               inj_en_i,
  input  logic                               inj_dir_i,
  input  logic [1:0]                         inj_mode_i,
  input  logic [15:0]                        inj_beat_i,
  input  logic [$clog2(PIPE_DATA_WIDTH)-1:0] inj_bit_i,
  output logic                               inj_done_o,
  output logic [BEAT_CNT_W-1:0]              beats_ab_o,
  output logic [BEAT_CNT_W-1:0]              beats_ba_o,
  output logic [DROP_CNT_W-1:0]              drops_o
);

  localparam int W     = PIPE_DATA_WIDTH;
  localparam int BIT_W = $clog2(PIPE_DATA_WIDTH);
  localparam int CNT_W = $clog2(LINKUP_CYCLES + 1);
  localparam logic [CNT_W-1:0] TRAIN_LOAD = CNT_W'(LINKUP_CYCLES - 1);

  pipe_ch_state_t        state_q, state_d;
  logic [CNT_W-1:0]      train_cnt_q, train_cnt_d;

  logic                  inj_en_q;
  logic                  inj_armed_q, inj_armed_d;
  logic                  inj_dir_q, inj_dir_d;
  pipe_inj_mode_t        inj_mode_q, inj_mode_d;
  logic [15:0]           inj_beat_q, inj_beat_d;
  logic [BIT_W-1:0]      inj_bit_q, inj_bit_d;
  logic [15:0]           inj_cnt_q, inj_cnt_d;

  logic [BEAT_CNT_W-1:0] beats_ab_q, beats_ab_d;
  logic [BEAT_CNT_W-1:0] beats_ba_q, beats_ba_d;
  logic [DROP_CNT_W-1:0] drops_q, drops_d;

  logic                  link_up;
  logic                  flush;
  logic                  acc_ab, acc_ba, inj_acc, inj_hit;
  logic [W-1:0]          flip_mask;
  logic                  ab_valid, ba_valid;
  logic [W-1:0]          ab_data, ba_data;

  // Training FSM next state: one cycle in RESET_WAIT, LINKUP_CYCLES in TRAINING,
  // link down from TRAINING/LINK_UP parks in FLUSH until the request drops.
  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    case (state_q)
      RESET_WAIT: begin
        state_d     = TRAINING;
        train_cnt_d = TRAIN_LOAD;
      end
      TRAINING: begin
        if (link_down_i) begin
          state_d = FLUSH;
        end else if (train_cnt_q == '0) begin
          state_d = LINK_UP;
        end else begin
          train_cnt_d = train_cnt_q - 1'b1;
        end
      end
      LINK_UP: begin
        if (link_down_i) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!link_down_i) begin
          state_d     = TRAINING;
          train_cnt_d = TRAIN_LOAD;
        end
      end
      default: state_d = RESET_WAIT;
    endcase
  end

  // Beat acceptance and injection applied at delay-line entry; a beat that shows
  // up in the same cycle as a link-down request is discarded.
  always_comb begin
    link_up   = (state_q == LINK_UP);
    flush     = (link_up && link_down_i) || (state_q == FLUSH);
    acc_ab    = link_up && !link_down_i && a_txvalid_i;
    acc_ba    = link_up && !link_down_i && b_txvalid_i;
    inj_acc   = inj_dir_q ? acc_ba : acc_ab;
    inj_hit   = inj_armed_q && inj_acc && (inj_cnt_q == inj_beat_q);
    flip_mask = {{(W-1){1'b0}}, 1'b1} << inj_bit_q;
    ab_valid  = acc_ab;
    ba_valid  = acc_ba;
    ab_data   = a_txdata_i;
    ba_data   = b_txdata_i;
    if (inj_hit) begin
      case (inj_mode_q)
        INJ_FLIP: begin
          if (inj_dir_q) ba_data = b_txdata_i ^ flip_mask;
          else           ab_data = a_txdata_i ^ flip_mask;
        end
        INJ_DROP: begin
          if (inj_dir_q) ba_valid = 1'b0;
          else           ab_valid = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Injection arming, beat counting and statistics counters
  always_comb begin
    inj_armed_d = inj_armed_q;
    inj_dir_d   = inj_dir_q;
    inj_mode_d  = inj_mode_q;
    inj_beat_d  = inj_beat_q;
    inj_bit_d   = inj_bit_q;
    inj_cnt_d   = inj_cnt_q;
    drops_d     = drops_q;
    beats_ab_d  = beats_ab_q + BEAT_CNT_W'(b_rxvalid_o);
    beats_ba_d  = beats_ba_q + BEAT_CNT_W'(a_rxvalid_o);

    if (flush) begin
      inj_armed_d = 1'b0;
    end else if (inj_armed_q) begin
      if (inj_hit) begin
        inj_armed_d = 1'b0;
        if (inj_mode_q == INJ_DROP) begin
          drops_d = sat_inc16(drops_q);
        end
      end else if (inj_acc) begin
        inj_cnt_d = inj_cnt_q + 1'b1;
      end
    end else if (link_up && inj_en_i && !inj_en_q) begin
      inj_armed_d = 1'b1;
      inj_dir_d   = inj_dir_i;
      inj_mode_d  = pipe_inj_mode_t'(inj_mode_i);
      inj_beat_d  = inj_beat_i;
      inj_bit_d   = inj_bit_i;
      inj_cnt_d   = '0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RESET_WAIT;
      train_cnt_q <= '0;
      inj_en_q    <= 1'b0;
      inj_armed_q <= 1'b0;
      inj_dir_q   <= 1'b0;
      inj_mode_q  <= INJ_NONE;
      inj_beat_q  <= '0;
      inj_bit_q   <= '0;
      inj_cnt_q   <= '0;
      beats_ab_q  <= '0;
      beats_ba_q  <= '0;
      drops_q     <= '0;
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      inj_en_q    <= inj_en_i;
      inj_armed_q <= inj_armed_d;
      inj_dir_q   <= inj_dir_d;
      inj_mode_q  <= inj_mode_d;
      inj_beat_q  <= inj_beat_d;
      inj_bit_q   <= inj_bit_d;
      inj_cnt_q   <= inj_cnt_d;
      beats_ab_q  <= beats_ab_d;
      beats_ba_q  <= beats_ba_d;
      drops_q     <= drops_d;
    end
  end

  pipe_delay_line #(.WIDTH(W), .DEPTH(LATENCY)) u_line_ab (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .valid_i (ab_valid),
    .data_i  (ab_data),
    .valid_o (b_rxvalid_o),
    .data_o  (b_rxdata_o)
  );

  pipe_delay_line #(.WIDTH(W), .DEPTH(LATENCY)) u_line_ba (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .valid_i (ba_valid),
    .data_i  (ba_data),
    .valid_o (a_rxvalid_o),
    .data_o  (a_rxdata_o)
  );

  assign link_up_o  = link_up;
  assign inj_done_o = inj_hit;
  assign beats_ab_o = beats_ab_q;
  assign beats_ba_o = beats_ba_q;
  assign drops_o    = drops_q;

endmodule
